// File: rtl/assoc_buffer_pkg.sv
// Shared definitions for the associative buffer clients: buffer command
// encodings, buffer_dump FSM state codes and the settle counter width helper.
package assoc_buffer_pkg;

  typedef logic [1:0] buf_ctrl_t;

  localparam buf_ctrl_t CTRL_NONE = 2'd0;
  localparam buf_ctrl_t CTRL_LOAD = 2'd1;
  localparam buf_ctrl_t CTRL_INCR = 2'd2;
  localparam buf_ctrl_t CTRL_CLR  = 2'd3;

  typedef logic [1:0] dump_state_t;

  localparam dump_state_t DUMP_IDLE = 2'd0;
  localparam dump_state_t DUMP_WAIT = 2'd1;
  localparam dump_state_t DUMP_EMIT = 2'd2;
  localparam dump_state_t DUMP_DONE = 2'd3;

  // Bits needed to hold SETTLE-1; never less than one.
  function automatic int settle_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that parks at zero; terminal is high while the count
// is zero. Used to wait for a buffer lookup to settle after a key change.
module settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign terminal = (count_reg == '0);

endmodule

// File: rtl/buffer_dump.sv
// Scans every key of the associative buffer and streams (key, data, hit) beats
// over valid/ready. Optional BUFFER_DUMP_SKIP_INVALID_EN suppresses miss beats.
module buffer_dump
  import assoc_buffer_pkg::*;
#(
  parameter int KEY_SIZE  = 2,
  parameter int DATA_SIZE = 4,
  parameter int SETTLE    = 1
) (
  input  logic                 clk,
  input  logic                 async_reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [1:0]           buf_ctrl,
  output logic [KEY_SIZE-1:0]  buf_key,
  input  logic [DATA_SIZE-1:0] buf_data_out,
  input  logic                 buf_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [KEY_SIZE-1:0]  out_key,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_hit,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int                 SW          = settle_width(SETTLE);
  localparam logic [SW-1:0]      SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [KEY_SIZE-1:0] LAST_KEY   = '1;

  dump_state_t          state_reg, state_next;
  logic [KEY_SIZE-1:0]  key_reg;
  logic                 out_valid_reg;
  logic [KEY_SIZE-1:0]  out_key_reg;
  logic [DATA_SIZE-1:0] out_data_reg;
  logic                 out_hit_reg;
  logic                 out_last_reg;

  logic timer_load;
  logic timer_tc;
  logic sample;
  logic handshake;
  logic is_last;
  logic skip_key;
  logic advance;
  logic begin_scan;

`ifdef BUFFER_DUMP_SKIP_INVALID_EN
  assign skip_key = ~buf_valid;
`else
  assign skip_key = 1'b0;
`endif

  assign begin_scan = (state_reg == DUMP_IDLE) && start;
  assign sample     = (state_reg == DUMP_WAIT) && timer_tc;
  assign handshake  = out_valid_reg && out_ready;
  assign is_last    = (key_reg == LAST_KEY);
  // Moving on to another key: either the beat was taken or the key was skipped.
  assign advance    = ((state_reg == DUMP_EMIT) && handshake) || (sample && skip_key);
  assign timer_load = begin_scan || (advance && !is_last);

  settle_timer #(
    .WIDTH(SW)
  ) u_settle_timer (
    .clk        (clk),
    .async_reset(async_reset),
    .load       (timer_load),
    .load_value (SETTLE_LOAD),
    .enable     (state_reg == DUMP_WAIT),
    .terminal   (timer_tc)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DUMP_IDLE: if (start) state_next = DUMP_WAIT;
      DUMP_WAIT: begin
        if (sample) begin
          if (!skip_key)    state_next = DUMP_EMIT;
          else if (is_last) state_next = DUMP_DONE;
          else              state_next = DUMP_WAIT;
        end
      end
      DUMP_EMIT: if (handshake) state_next = is_last ? DUMP_DONE : DUMP_WAIT;
      default:   state_next = DUMP_IDLE;
    endcase
    if (abort) state_next = DUMP_IDLE;
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_reg <= DUMP_IDLE;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (!abort) begin
        if (begin_scan) begin
          key_reg <= '0;
        end else if (advance && !is_last) begin
          key_reg <= key_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      out_valid_reg <= 1'b0;
      out_key_reg   <= '0;
      out_data_reg  <= '0;
      out_hit_reg   <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      if (sample && !skip_key) begin
        out_key_reg   <= key_reg;
        out_data_reg  <= buf_data_out;
        out_hit_reg   <= buf_valid;
        out_last_reg  <= is_last;
        out_valid_reg <= 1'b1;
      end else if (handshake) begin
        out_valid_reg <= 1'b0;
      end
      // Abort wins over a beat being loaded in the same cycle.
      if (abort) out_valid_reg <= 1'b0;
    end
  end

  assign buf_ctrl  = CTRL_NONE;
  assign buf_key   = key_reg;
  assign out_valid = out_valid_reg;
  assign out_key   = out_key_reg;
  assign out_data  = out_data_reg;
  assign out_hit   = out_hit_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg == DUMP_WAIT) || (state_reg == DUMP_EMIT);
  assign done      = (state_reg == DUMP_DONE);

endmodule

// File: doc/buffer_dump.md
# buffer_dump

Read-side companion to the button-driven associative buffer front end: on a start pulse it walks every key of the associative buffer, samples `data_out`/`valid` for each, and streams the results out over a valid/ready interface (to a display multiplexer, UART formatter or testbench monitor). It never modifies buffer contents: `buf_ctrl` is held at NONE. It sits beside the write path and shares the buffer's `key` input through a top-level mux selected by `busy`.

## Interface
Parameters:
- `KEY_SIZE`, 2, key width; entries scanned = 2^KEY_SIZE
- `DATA_SIZE`, 4, data width
- `SETTLE`, 1, cycles from a key change to sampling the buffer outputs (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `async_reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a scan; sampled in IDLE only
- `abort`  in  1  terminate scan immediately
- `buf_ctrl`  out  2  buffer command; constant NONE (2'd0)
- `buf_key`  out  KEY_SIZE  key presented to buffer
- `buf_data_out`  in  DATA_SIZE  buffer lookup data
- `buf_valid`  in  1  buffer lookup hit
- `out_valid`  out  1  stream beat valid
- `out_ready`  in  1  stream beat accepted when high with `out_valid`
- `out_key`  out  KEY_SIZE  key of beat
- `out_data`  out  DATA_SIZE  sampled data
- `out_hit`  out  1  sampled `buf_valid`
- `out_last`  out  1  beat is for key 2^KEY_SIZE−1
- `busy`  out  1  scan in progress (WAIT or EMIT)
- `done`  out  1  one-cycle pulse at scan end

## Operation
- States: IDLE, WAIT, EMIT, DONE.
- IDLE: `start`=1 → key counter ← 0, settle counter ← SETTLE−1, → WAIT.
- WAIT: `buf_key` = key counter; count down; on final WAIT cycle register `buf_data_out`, `buf_valid`, key into out registers, set `out_valid`, → EMIT.
- EMIT: out registers and `out_valid` stable until `out_valid && out_ready`. On handshake: last key → DONE; else key+1, reload settle counter, → WAIT.
- DONE: `done`=1 for one cycle → IDLE. `start` ignored in every state but IDLE.
- `abort`=1 in any state: next state IDLE, `out_valid` cleared, no `done` pulse; a beat handshaking in the same cycle counts as accepted.
- Key counter is KEY_SIZE bits, no wrap: termination by last-key compare.
- `buf_key` holds its last value in IDLE/DONE.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-scan: immediate return to IDLE, no `done`.

## Timing
- `start` high at edge 0 → WAIT from cycle 1, `buf_key`=0 from cycle 1.
- First `out_valid` at cycle 1+SETTLE.
- With `out_ready` held high: one beat every SETTLE+1 cycles; `done` at cycle (SETTLE+1)·2^KEY_SIZE+1; defaults → cycle 9.
- `busy` high exactly in WAIT/EMIT; low in the `done` cycle.
- Backpressure stalls in EMIT indefinitely; `buf_key` unchanged while stalled.

## Configuration
- `BUFFER_DUMP_SKIP_INVALID_EN` defined: at WAIT end, if `buf_valid`=0 no beat is emitted; go straight to next key (or DONE if last key). `out_hit` therefore always 1; `out_last` only marks key 2^KEY_SIZE−1 when that key is a hit. `done` still pulses.
- Not defined: every key emits exactly one beat, hits and misses alike.

## Structure
- Package `assoc_buffer_pkg`: ctrl encodings NONE/LOAD/INCR/CLR (0..3), shared with the write front end; `buffer_dump` state enum.
- One sub-module: `settle_timer` (loadable down-counter with terminal-count output), reusable by other buffer clients.

## Test plan
- Defaults, buffer loaded keys 0..3 with 4'h5,4'hA,none,4'h3, `out_ready`=1, `start` pulse → beats (0,5,hit),(1,A,hit),(2,x,miss),(3,3,hit,last); `done` at cycle 9.
- Same contents, `out_ready` low for 5 cycles at beat 1 → beat 1 fields stable throughout, `buf_key`=1 held, `done` delayed by 5 cycles.
- With `BUFFER_DUMP_SKIP_INVALID_EN`, keys 1 and 3 empty → exactly two beats (keys 0,2), `out_last` never high, `done` pulses once.
- `abort` during second EMIT → `out_valid` 0 next cycle, state IDLE, no `done`; new `start` restarts at key 0.
- `start` pulsed while busy and in DONE → ignored, beat count stays 4.
- `async_reset` asserted mid-WAIT between edges → all outputs 0 immediately; SETTLE=3 run afterwards gives first `out_valid` at cycle 4.
